// File: rtl/uart_wb_bridge_if.sv
// uart_wb_bridge_if: UART byte stream and Wishbone master signals of the bridge
interface uart_wb_bridge_if;
  logic [7:0] rx_data_i;
  logic rx_valid_i;
  logic [7:0] tx_data_o;
  logic tx_valid_o;
  logic tx_ready_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic wb_we_o;
  logic [3:0] wb_sel_o;
  logic wb_stb_o;
  logic wb_cyc_o;
  logic wb_ack_i;
  logic wb_stall_i;
  logic busy_o;
  modport master(
    input rx_data_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i, wb_stall_i,
    output tx_data_o, tx_valid_o, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, busy_o
  );
  modport slave(
    output rx_data_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i, wb_stall_i,
    input tx_data_o, tx_valid_o, wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, busy_o
  );
endinterface

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: byte-command UART to pipelined Wishbone master bridge
module uart_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_i,
  input logic rst_i,
  uart_wb_bridge_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, WAIT_ACK, RESP} state_t;
  state_t state;
  logic is_write;
  logic [1:0] cnt;
  logic [TW-1:0] tmo;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [23:0] rest;
  logic [1:0] left;
  logic [7:0] tx_data;
  logic tx_valid;
  logic cyc;
  logic stb;
  logic we;
  logic [3:0] sel;
  logic done;
  logic expired;
  assign bus.tx_data_o = tx_data;
  assign bus.tx_valid_o = tx_valid;
  assign bus.wb_adr_o = adr;
  assign bus.wb_dat_o = dat;
  assign bus.wb_we_o = we;
  assign bus.wb_sel_o = sel;
  assign bus.wb_stb_o = stb;
  assign bus.wb_cyc_o = cyc;
  assign bus.busy_o = state != IDLE;
  // completion: ack at acceptance or while waiting; an ack beats a simultaneous timeout
  assign done = bus.wb_ack_i && (state == WAIT_ACK || (state == REQ && !bus.wb_stall_i));
  assign expired = state == WAIT_ACK && !bus.wb_ack_i && int'(tmo) + 1 >= TIMEOUT_CYCLES;
  // command parser, bus master and response sequencer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      is_write <= 1'b0;
      cnt <= '0;
      tmo <= '0;
      adr <= '0;
      dat <= '0;
      rest <= '0;
      left <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      cyc <= 1'b0;
      stb <= 1'b0;
      we <= 1'b0;
      sel <= '0;
    end else begin
      case (state)
        IDLE: if (bus.rx_valid_i) begin
          if (bus.rx_data_i == 8'h01 || bus.rx_data_i == 8'h02) begin
            is_write <= bus.rx_data_i == 8'h01;
            cnt <= '0;
            state <= ADDR;
          end else begin
            tx_data <= 8'hEE;
            left <= '0;
            tx_valid <= 1'b1;
            state <= RESP;
          end
        end
        ADDR: if (bus.rx_valid_i) begin
          adr[{cnt, 3'b000} +: 8] <= bus.rx_data_i;
          cnt <= cnt + 1'b1;
          if (cnt == 2'd3 && is_write) state <= DATA;
          if (cnt == 2'd3 && !is_write) begin
            state <= REQ;
            cyc <= 1'b1;
            stb <= 1'b1;
            we <= 1'b0;
            sel <= 4'hF;
          end
        end
        DATA: if (bus.rx_valid_i) begin
          dat[{cnt, 3'b000} +: 8] <= bus.rx_data_i;
          cnt <= cnt + 1'b1;
          if (cnt == 2'd3) begin
            state <= REQ;
            cyc <= 1'b1;
            stb <= 1'b1;
            we <= 1'b1;
            sel <= 4'hF;
          end
        end
        REQ: if (!bus.wb_stall_i) begin
          stb <= 1'b0;
          tmo <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: tmo <= tmo + 1'b1;
        RESP: if (tx_valid && bus.tx_ready_i) begin
          if (left == 2'd0) begin
            tx_valid <= 1'b0;
            state <= IDLE;
          end else begin
            tx_data <= rest[7:0];
            rest <= rest >> 8;
            left <= left - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (done || expired) begin
        cyc <= 1'b0;
        stb <= 1'b0;
        we <= 1'b0;
        sel <= '0;
        tx_valid <= 1'b1;
        state <= RESP;
        tx_data <= expired ? 8'hEE : is_write ? 8'hA5 : bus.wb_dat_i[7:0];
        rest <= bus.wb_dat_i[31:8];
        left <= (expired || is_write) ? 2'd0 : 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge: scenario and randomized checks of the UART to Wishbone bridge
module tb_uart_wb_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_wb_bridge_if bus();
  uart_wb_bridge #(.TIMEOUT_CYCLES(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int stb_n, cyc_n, unstable, hold_err, got_n;
  logic [31:0] got_v;
  logic [31:0] obs_adr, obs_dat;
  logic obs_we;
  logic [3:0] obs_sel;

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data_i = b;
    bus.rx_valid_i = 1'b1;
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d);
    send_byte(w ? 8'h01 : 8'h02);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (w) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  // Wishbone slave: stalls the first stall_n strobe cycles, acks ack_d cycles after acceptance (never if negative)
  task automatic bus_phase(input int stall_n, input int ack_d, input logic [31:0] rd, input bit junk);
    int acc = -1;
    stb_n = 0;
    cyc_n = 0;
    unstable = 0;
    obs_adr = bus.wb_adr_o;
    obs_dat = bus.wb_dat_o;
    obs_we = bus.wb_we_o;
    obs_sel = bus.wb_sel_o;
    for (int c = 0; c < 64; c++) begin
      if (!bus.wb_cyc_o) begin
        if (bus.wb_stb_o) unstable++;
        break;
      end
      cyc_n++;
      if ({bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o, bus.wb_sel_o} !== {obs_adr, obs_dat, obs_we, obs_sel}) unstable++;
      if (bus.wb_stb_o) stb_n++;
      bus.wb_stall_i = bus.wb_stb_o && stb_n <= stall_n;
      if (bus.wb_stb_o && !bus.wb_stall_i) acc = c;
      bus.wb_ack_i = acc >= 0 && ack_d >= 0 && c - acc == ack_d;
      bus.wb_dat_i = bus.wb_ack_i ? rd : $urandom;
      bus.rx_valid_i = junk && c == 1;
      bus.rx_data_i = 8'h01;
      @(negedge clk);
    end
    bus.wb_stall_i = 1'b0;
    bus.wb_ack_i = 1'b0;
    bus.rx_valid_i = 1'b0;
  endtask

  // UART transmitter: holds ready low for hold_n cycles, optionally random afterwards; injects one rx byte at cycle inj
  task automatic collect(input int hold_n, input int inj, input bit rnd);
    logic [7:0] prev = '0;
    bit held = 1'b0;
    got_n = 0;
    got_v = '0;
    hold_err = 0;
    for (int c = 0; c < 100; c++) begin
      if (!bus.tx_valid_o && !bus.busy_o) break;
      if (held && (!bus.tx_valid_o || bus.tx_data_o !== prev)) hold_err++;
      bus.tx_ready_i = c >= hold_n && (!rnd || $urandom_range(0, 1) == 1);
      bus.rx_valid_i = c == inj;
      bus.rx_data_i = 8'h02;
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        if (got_n < 4) got_v[8*got_n +: 8] = bus.tx_data_o;
        got_n++;
      end
      held = bus.tx_valid_o && !bus.tx_ready_i;
      prev = bus.tx_data_o;
      @(negedge clk);
    end
    bus.tx_ready_i = 1'b0;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o, bus.tx_valid_o, bus.tx_data_o, bus.busy_o} !== '0)
      begin failures++; $display("FAIL reset_outputs got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h txv=%b txd=%h busy=%b exp all zero",
        bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o, bus.tx_valid_o, bus.tx_data_o, bus.busy_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d);
    send_cmd(1'b1, a, d);
    bus_phase(0, 1, 32'h0, 1'b0);
    checks++;
    if ({obs_adr, obs_dat, obs_we, obs_sel} !== {a, d, 1'b1, 4'hF})
      begin failures++; $display("FAIL write_bus got adr=%h dat=%h we=%b sel=%h exp %h %h 1 f", obs_adr, obs_dat, obs_we, obs_sel, a, d); end
    checks++;
    if (stb_n != 1 || cyc_n != 2 || unstable != 0)
      begin failures++; $display("FAIL write_timing got stb=%0d cyc=%0d unstable=%0d exp 1 2 0", stb_n, cyc_n, unstable); end
    collect(0, -1, 1'b0);
    checks++;
    if (got_n != 1 || got_v[7:0] !== 8'hA5 || bus.busy_o !== 1'b0)
      begin failures++; $display("FAIL write_resp got n=%0d byte=%h busy=%b exp 1 a5 0", got_n, got_v[7:0], bus.busy_o); end
  endtask

  task automatic test_read_stall;
    send_cmd(1'b0, 32'h00000004, 32'h0);
    bus_phase(3, 1, 32'h12345678, 1'b0);
    checks++;
    if ({obs_adr, obs_we, obs_sel} !== {32'h00000004, 1'b0, 4'hF})
      begin failures++; $display("FAIL read_bus got adr=%h we=%b sel=%h exp 00000004 0 f", obs_adr, obs_we, obs_sel); end
    checks++;
    if (stb_n != 4 || cyc_n != 5 || unstable != 0)
      begin failures++; $display("FAIL read_stall_timing got stb=%0d cyc=%0d unstable=%0d exp 4 5 0", stb_n, cyc_n, unstable); end
    collect(0, -1, 1'b0);
    checks++;
    if (got_n != 4 || got_v !== 32'h12345678)
      begin failures++; $display("FAIL read_resp got n=%0d bytes(le)=%h exp 4 12345678", got_n, got_v); end
  endtask

  task automatic test_bad_cmd;
    send_byte(8'h7F);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.tx_valid_o, bus.tx_data_o, bus.busy_o} !== {1'b0, 1'b0, 1'b1, 8'hEE, 1'b1})
      begin failures++; $display("FAIL bad_cmd_entry got cyc=%b stb=%b txv=%b txd=%h busy=%b exp 0 0 1 ee 1",
        bus.wb_cyc_o, bus.wb_stb_o, bus.tx_valid_o, bus.tx_data_o, bus.busy_o); end
    collect(2, -1, 1'b0);
    checks++;
    if (got_n != 1 || got_v[7:0] !== 8'hEE || bus.busy_o !== 1'b0 || bus.wb_cyc_o !== 1'b0 || hold_err != 0)
      begin failures++; $display("FAIL bad_cmd_resp got n=%0d byte=%h busy=%b cyc=%b hold=%0d exp 1 ee 0 0 0", got_n, got_v[7:0], bus.busy_o, bus.wb_cyc_o, hold_err); end
  endtask

  task automatic test_timeout;
    send_cmd(1'b0, 32'hC0FFEE00, 32'h0);
    bus_phase(0, -1, 32'h0, 1'b0);
    checks++;
    if (stb_n != 1 || cyc_n != 9)
      begin failures++; $display("FAIL timeout_timing got stb=%0d cyc=%0d exp 1 9", stb_n, cyc_n); end
    collect(0, -1, 1'b0);
    checks++;
    if (got_n != 1 || got_v[7:0] !== 8'hEE)
      begin failures++; $display("FAIL timeout_resp got n=%0d byte=%h exp 1 ee", got_n, got_v[7:0]); end
  endtask

  task automatic test_ack_at_timeout;
    send_cmd(1'b0, 32'h00000100, 32'h0);
    bus_phase(0, 8, 32'hCAFEF00D, 1'b0);
    checks++;
    if (cyc_n != 9)
      begin failures++; $display("FAIL ack_at_timeout_timing got cyc=%0d exp 9", cyc_n); end
    collect(0, -1, 1'b0);
    checks++;
    if (got_n != 4 || got_v !== 32'hCAFEF00D)
      begin failures++; $display("FAIL ack_at_timeout_resp got n=%0d bytes(le)=%h exp 4 cafef00d", got_n, got_v); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd = $urandom;
    send_cmd(1'b0, $urandom, 32'h0);
    bus_phase(0, 0, rd, 1'b0);
    collect(5, 2, 1'b0);
    checks++;
    if (got_n != 4 || got_v !== rd || hold_err != 0)
      begin failures++; $display("FAIL backpressure_resp got n=%0d bytes(le)=%h hold_err=%0d exp 4 %h 0", got_n, got_v, hold_err, rd); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.tx_valid_o !== 1'b0)
      begin failures++; $display("FAIL overrun_ignored got busy=%b txv=%b exp 0 0", bus.busy_o, bus.tx_valid_o); end
  endtask

  task automatic test_reset_mid;
    int txv = 0;
    send_cmd(1'b0, 32'h00000200, 32'h0);
    bus.wb_stall_i = 1'b0;
    bus.wb_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o} !== 3'b101)
      begin failures++; $display("FAIL reset_mid_wait got cyc=%b stb=%b busy=%b exp 1 0 1", bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o, bus.tx_valid_o, bus.wb_adr_o} !== '0)
      begin failures++; $display("FAIL reset_mid_async got cyc=%b stb=%b busy=%b txv=%b adr=%h exp all zero",
        bus.wb_cyc_o, bus.wb_stb_o, bus.busy_o, bus.tx_valid_o, bus.wb_adr_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.tx_valid_o || bus.busy_o) txv++;
    end
    bus.tx_ready_i = 1'b0;
    checks++;
    if (txv != 0)
      begin failures++; $display("FAIL reset_mid_no_tx got active_cycles=%0d exp 0", txv); end
    test_write($urandom, $urandom);
  endtask

  // random transactions against a transaction-level model of the byte protocol
  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      bit w = $urandom_range(0, 1) == 1;
      bit bad = $urandom_range(0, 7) == 0;
      int stall_n = $urandom_range(0, 3);
      int ack_d = $urandom_range(0, 9);
      logic [31:0] a = $urandom;
      logic [31:0] d = $urandom;
      logic [31:0] rd = $urandom;
      logic [7:0] b = $urandom;
      int exp_n;
      logic [31:0] exp_v;
      if (ack_d == 9) ack_d = -1;
      if (bad) begin
        if (b == 8'h01 || b == 8'h02) b = 8'h00;
        send_byte(b);
        exp_n = 1;
        exp_v = 32'hEE;
        checks++;
        if (bus.wb_cyc_o !== 1'b0)
          begin failures++; $display("FAIL rand_bad_no_bus iter=%0d got cyc=%b exp 0", n, bus.wb_cyc_o); end
      end else begin
        send_cmd(w, a, d);
        bus_phase(stall_n, ack_d, rd, 1'b1);
        checks++;
        if ({obs_adr, obs_we, obs_sel} !== {a, w, 4'hF} || (w && obs_dat !== d) || unstable != 0)
          begin failures++; $display("FAIL rand_bus iter=%0d got adr=%h dat=%h we=%b sel=%h unstable=%0d exp %h %h %b f 0",
            n, obs_adr, obs_dat, obs_we, obs_sel, unstable, a, d, w); end
        checks++;
        if (stb_n != stall_n + 1 || cyc_n != stall_n + 1 + (ack_d < 0 ? 8 : ack_d))
          begin failures++; $display("FAIL rand_timing iter=%0d got stb=%0d cyc=%0d exp %0d %0d",
            n, stb_n, cyc_n, stall_n + 1, stall_n + 1 + (ack_d < 0 ? 8 : ack_d)); end
        exp_n = (ack_d < 0 || w) ? 1 : 4;
        exp_v = ack_d < 0 ? 32'hEE : w ? 32'hA5 : rd;
      end
      collect($urandom_range(0, 3), -1, 1'b1);
      checks++;
      if (got_n != exp_n || got_v !== exp_v || hold_err != 0 || bus.busy_o !== 1'b0)
        begin failures++; $display("FAIL rand_resp iter=%0d got n=%0d bytes(le)=%h hold_err=%0d busy=%b exp %0d %h 0 0",
          n, got_n, got_v, hold_err, bus.busy_o, exp_n, exp_v); end
    end
  endtask

  initial begin
    bus.rx_data_i = '0;
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b0;
    bus.wb_dat_i = '0;
    bus.wb_ack_i = 1'b0;
    bus.wb_stall_i = 1'b0;
    test_reset();
    test_write(32'h40000010, 32'hDEADBEEF);
    test_read_stall();
    test_bad_cmd();
    test_timeout();
    test_ack_at_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
